// File: rtl/lsu_mem_port_if.sv
// Data-memory bus between the load/store port (master) and a single-ported
// data memory with a ready handshake (slave).
interface lsu_mem_port_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store port: runs one decoded memory operation against a ready-handshake
// data memory, stalling the core and formatting store lanes and load results.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [2:0]            RW_type_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  stall_o,
    output logic [31:0]           load_data_o,
    output logic                  mem_err_o,
    lsu_mem_port_if.master        mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        err_q;
    logic [31:0] load_data_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [2:0]  type_q;
    logic [1:0]  off_q;

    logic        access_s;
    logic        type_ok_s;
    logic        misalign_s;
    logic        err_s;
    logic        stall_s;

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   store_strb = 4'b0001 << off;
            2'b01:   store_strb = off[1] ? 4'b1100 : 4'b0011;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'b00:   store_data = {4{w[7:0]}};
            2'b01:   store_data = {2{w[15:0]}};
            default: store_data = w;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] t, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {off, 3'b000};
        case (t)
            3'b000:  load_fmt = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_fmt = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_fmt = {24'd0, sh[7:0]};
            3'b101:  load_fmt = {16'd0, sh[15:0]};
            default: load_fmt = rd;
        endcase
    endfunction

    // Decode legality of the requested access (unsigned loads have no store form)
    always_comb begin
        access_s  = MemRead_i | MemWrite_i;
        type_ok_s = 1'b0;
        case (RW_type_i)
            3'b000, 3'b001, 3'b010: type_ok_s = 1'b1;
            3'b100, 3'b101:         type_ok_s = MemRead_i;
            default:                type_ok_s = 1'b0;
        endcase
        misalign_s = 1'b0;
        case (RW_type_i[1:0])
            2'b01:   misalign_s = addr_i[0];
            2'b10:   misalign_s = (addr_i[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
        err_s = (MemRead_i & MemWrite_i) | ~type_ok_s | misalign_s;
    end

    // Stall follows the access inputs while idle so the core holds them
    always_comb begin
        stall_s = 1'b0;
        case (state_q)
            S_IDLE:  stall_s = access_s;
            S_BUSY:  stall_s = 1'b1;
            S_DONE:  stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Access FSM with registered bus outputs, load result and fault flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            load_data_q <= 32'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wstrb_q     <= 4'd0;
            wdata_q     <= 32'd0;
            type_q      <= 3'd0;
            off_q       <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access_s && err_s) begin
                        state_q     <= S_DONE;
                        err_q       <= 1'b1;
                        load_data_q <= 32'd0;
                    end else if (access_s) begin
                        state_q <= S_BUSY;
                        cnt_q   <= 8'd0;
                        req_q   <= 1'b1;
                        we_q    <= MemWrite_i;
                        addr_q  <= {addr_i[31:2], 2'b00};
                        wstrb_q <= MemWrite_i ? store_strb(RW_type_i[1:0], addr_i[1:0]) : 4'd0;
                        wdata_q <= MemWrite_i ? store_data(RW_type_i[1:0], wdata_i) : 32'd0;
                        type_q  <= RW_type_i;
                        off_q   <= addr_i[1:0];
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (mem.mem_ready || (cnt_q == TO_LAST)) begin
                        state_q     <= S_DONE;
                        err_q       <= ~mem.mem_ready;
                        load_data_q <= (mem.mem_ready && !we_q) ?
                                       load_fmt(type_q, off_q, mem.mem_rdata) : 32'd0;
                        cnt_q       <= 8'd0;
                        req_q       <= 1'b0;
                        we_q        <= 1'b0;
                        addr_q      <= 32'd0;
                        wstrb_q     <= 4'd0;
                        wdata_q     <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= 8'd0;
                    err_q       <= 1'b0;
                    load_data_q <= 32'd0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 8'd0;
                    err_q   <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o       = stall_s;
    assign load_data_o   = load_data_q;
    assign mem_err_o     = err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wstrb = wstrb_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized bench for lsu_mem_port: a bench-side memory with programmable
// latency plus a rule-level reference model of each access outcome.
module tb_lsu_mem_port;
    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  RW_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        mem_err;

    int n_cmp;
    int n_bad;

    lsu_mem_port_if bus ();

    lsu_mem_port #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemRead_i   (MemRead),
        .MemWrite_i  (MemWrite),
        .RW_type_i   (RW_type),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .stall_o     (stall),
        .load_data_o (load_data),
        .mem_err_o   (mem_err),
        .mem         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_legal(input bit rd, input bit wr, input int t, input logic [31:0] a);
        int size;
        size = t % 4;
        if (rd && wr) return 1'b0;
        if (rd && !(t inside {0, 1, 2, 4, 5})) return 1'b0;
        if (wr && !(t inside {0, 1, 2})) return 1'b0;
        if (size == 1 && (a % 2) != 0) return 1'b0;
        if (size == 2 && (a % 4) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(input int t, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * (a % 4));
        case (t)
            0: return ((s & 32'hFF) >= 32'h80) ? (s | 32'hFFFF_FF00) : (s & 32'hFF);
            1: return ((s & 32'hFFFF) >= 32'h8000) ? (s | 32'hFFFF_0000) : (s & 32'hFFFF);
            4: return s & 32'hFF;
            5: return s & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_strb(input int t, input logic [31:0] a);
        case (t % 4)
            0: return 32'(1 << (a % 4));
            1: return ((a % 4) == 2) ? 32'hC : 32'h3;
            default: return 32'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input int t, input logic [31:0] w);
        case (t % 4)
            0: return (w & 32'hFF) * 32'h0101_0101;
            1: return (w & 32'hFFFF) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    // Drives one access (called just after a rising edge) and checks it to completion.
    task automatic run_access(input bit rd, input bit wr, input int t, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdv, input int lat);
        bit acc, legal, tmo, done;
        int e_busy, e_stall, busy, stalls;
        logic [31:0] e_load;
        logic        e_err;
        acc    = rd || wr;
        legal  = ref_legal(rd, wr, t, a);
        tmo    = acc && legal && (lat >= TO);
        e_busy = (!acc || !legal) ? 0 : (tmo ? TO : lat + 1);
        e_stall = !acc ? 0 : e_busy + 1;
        e_err  = acc && (!legal || tmo);
        e_load = (acc && legal && rd && !tmo) ? ref_load(t, a, rdv) : 32'd0;

        MemRead = rd; MemWrite = wr; RW_type = 3'(t); addr = a; wdata = wd;
        busy = 0; stalls = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall) begin
                stalls++;
                check_eq("err_while_stalled", 32'(mem_err), 32'd0);
                if (bus.mem_req) begin
                    busy++;
                    check_eq("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
                    check_eq("mem_we", 32'(bus.mem_we), 32'(wr));
                    check_eq("mem_wstrb", 32'(bus.mem_wstrb), wr ? ref_strb(t, a) : 32'd0);
                    if (wr) check_eq("mem_wdata", bus.mem_wdata, ref_wdata(t, wd));
                    bus.mem_ready = (busy > lat);
                    bus.mem_rdata = (busy > lat) ? rdv : $urandom;
                end
            end else begin
                done = 1'b1;
                check_eq("stall_cycles", 32'(stalls), 32'(e_stall));
                check_eq("req_cycles", 32'(busy), 32'(e_busy));
                check_eq("load_data", load_data, e_load);
                check_eq("mem_err", 32'(mem_err), 32'(e_err));
                check_eq("req_in_done", 32'(bus.mem_req), 32'd0);
                check_eq("wstrb_in_done", 32'(bus.mem_wstrb), 32'd0);
                bus.mem_ready = 1'($urandom);
                bus.mem_rdata = $urandom;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check_eq("access_budget", 32'd0, 32'd1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; RW_type = 3'd0; addr = 32'd0; wdata = 32'd0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
        #12;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_req", 32'(bus.mem_req), 32'd0);
        check_eq("rst_addr", bus.mem_addr, 32'd0);
        check_eq("rst_load", load_data, 32'd0);
        check_eq("rst_err", 32'(mem_err), 32'd0);
        MemRead = 1'b1;
        #1 check_eq("rst_stall_follows", 32'(stall), 32'd1);
        MemRead = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_access(1, 0, 2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        run_access(1, 0, 0, 32'h103, 32'h0, 32'h80FF_1234, 0);
        run_access(1, 0, 4, 32'h103, 32'h0, 32'h80FF_1234, 1);
        run_access(1, 0, 1, 32'h102, 32'h0, 32'h80FF_1234, 0);
        run_access(0, 1, 0, 32'h21, 32'h0000_00AB, 32'h0, 0);
        run_access(0, 1, 1, 32'h22, 32'h0000_1234, 32'h0, 3);
        run_access(1, 0, 2, 32'h101, 32'h0, 32'h1111_1111, 0);
        run_access(1, 1, 2, 32'h100, 32'h0, 32'h1111_1111, 0);
        run_access(1, 0, 3, 32'h100, 32'h0, 32'h1111_1111, 0);
        run_access(0, 1, 4, 32'h100, 32'h55, 32'h0, 0);
        run_access(1, 0, 2, 32'h200, 32'h0, 32'hCAFE_F00D, 10);
        run_access(1, 0, 5, 32'h202, 32'h0, 32'hCAFE_F00D, 2);
        run_access(0, 0, 2, 32'h0, 32'h0, 32'h0, 0);

        // Reset while an access is in flight
        MemRead = 1'b1; MemWrite = 1'b0; RW_type = 3'd2; addr = 32'h300;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        check_eq("busy_req", 32'(bus.mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_req_drop", 32'(bus.mem_req), 32'd0);
        check_eq("async_stall_idle", 32'(stall), 32'd1);
        MemRead = 1'b0;
        #1;
        check_eq("rst_stall_off", 32'(stall), 32'd0);
        check_eq("rst_addr2", bus.mem_addr, 32'd0);
        check_eq("rst_strb2", 32'(bus.mem_wstrb), 32'd0);
        check_eq("rst_we2", 32'(bus.mem_we), 32'd0);
        check_eq("rst_load2", load_data, 32'd0);
        check_eq("rst_err2", 32'(mem_err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_access(1, 0, 2, 32'h300, 32'h0, 32'h0BAD_CAFE, 1);

        for (int i = 0; i < 300; i++) begin
            int  sel;
            bit  rd, wr;
            sel = int'($urandom_range(0, 9));
            rd  = (sel == 1) || (sel >= 2 && sel <= 5);
            wr  = (sel == 1) || (sel >= 6);
            run_access(rd, wr, int'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 5)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
